mimosa_caretaker: RTL and testbench
===================================

MIMOSA_CARETAKER -- requirements
Module: mimosa_caretaker

Interface
REQ-001 Parameter TICK_DIV, default 1000: clk cycles per model_clk half-period; legal range 2..65535.
REQ-002 Parameter STIM_HOLD, default 4: model_clk rising edges a stimulus is held; legal range 1..255.
REQ-003 Parameter COOLDOWN, default 8: model_clk rising edges of forced quiet after a stimulus; legal range 1..255.
REQ-004 Parameter SLEEP_STATE, default 2'b01: physical-state code that suppresses automatic stimuli.
REQ-005 clk  input  1  system clock; one clock domain only.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 status  input  8  pet status bus, fields {state[7:6], pleasure_ind[5:4], stress_ind[3:2], energy_ind[1:0]}; indicator 2'b00 = lowest range, 2'b11 = highest.
REQ-008 auto_en  input  1  enables the automatic care policy.
REQ-009 manual_valid  input  1  one-cycle request to apply manual_stim.
REQ-010 manual_stim  input  7  manual stimulus pattern, same bit order as stim.
REQ-011 model_clk  output  1  square-wave heartbeat clock for the pet model.
REQ-012 stim  output  7  stimulus lines to the pet (bit0 soothe, bit1 feed, bit2 play, bits6:3 manual only).
REQ-013 busy  output  1  high whenever the FSM is not IDLE.
REQ-014 manual_drop  output  1  one-cycle pulse when a manual request is discarded.
REQ-015 stim_count  output  8  number of stimulus episodes started, saturating.

Function
REQ-016 Divider counts 0..TICK_DIV-1; on terminal count it returns to 0 and model_clk toggles; period = 2*TICK_DIV clk cycles.
REQ-017 rise_evt = cycle model_clk toggles 0->1; fall_evt = cycle it toggles 1->0; both internal single-cycle strobes.
REQ-018 stim, together with state transitions from ARM and from the final HOLD/COOLDOWN cycle, changes only on the clk edge coinciding with fall_evt, so stim is stable around every model_clk rising edge.
REQ-019 FSM states: IDLE, ARM, HOLD, COOLDOWN; busy = (state != IDLE).
REQ-020 IDLE: manual_valid=1 latches manual_stim into pend and moves to ARM the next cycle; manual takes priority over auto in the same cycle.
REQ-021 IDLE, auto_en=1, no manual_valid, state field != SLEEP_STATE: pend selected by priority stress_ind==2'b11 -> 7'b0000001; else energy_ind==2'b00 -> 7'b0000010; else pleasure_ind==2'b00 -> 7'b0000100; else stay IDLE.
REQ-022 A manual request with manual_stim==0 is accepted and runs a normal episode with stim held at 0.
REQ-023 ARM: on fall_evt, stim <= pend, hold counter cleared, stim_count increments (saturate at 255), go HOLD.
REQ-024 HOLD: hold counter increments on each rise_evt; once it equals STIM_HOLD, the next fall_evt sets stim <= 0, clears the counter, and goes COOLDOWN.
REQ-025 COOLDOWN: counter increments on each rise_evt; once it equals COOLDOWN, the next fall_evt goes IDLE.
REQ-026 manual_valid in ARM, HOLD, or COOLDOWN: request ignored, manual_drop pulses 1 cycle; the pend and stim values are unchanged.
REQ-027 Status and auto_en changes after leaving IDLE do not alter the running episode.
REQ-028 rise_evt and fall_evt never coincide; a request arriving on a fall_evt cycle waits for the following fall_evt.

Reset
REQ-029 rst=1 asynchronously forces: model_clk=0, divider=0, stim=0, pend=0, state IDLE, busy=0, manual_drop=0, stim_count=0, counters=0.
REQ-030 rst asserted mid-episode aborts it immediately; stim returns to 0 without waiting for fall_evt.
REQ-031 After rst deasserts, the first model_clk toggle occurs TICK_DIV clk cycles later.

Verification (TICK_DIV=2, STIM_HOLD=2, COOLDOWN=1)
REQ-032 Reset release, idle inputs -> model_clk period 4 cycles, stim=0, busy=0, stim_count=0 for 100 cycles.
REQ-033 manual_valid with manual_stim=7'h55 in IDLE -> stim=7'h55 from the first fall_evt for exactly 2 rising edges (8 clk), then 0; busy clears 1 model period later; stim_count=1.
REQ-034 auto_en=1, status=8'b00_00_11_00 -> stim=7'b0000001 (stress beats energy); status=8'b01_00_11_00 -> no episode (sleep).
REQ-035 manual_valid during HOLD -> manual_drop=1 for 1 cycle, stim unchanged, stim_count unchanged.
REQ-036 rst pulse during HOLD with stim=7'h02 -> stim=0, model_clk=0, busy=0 in the same cycle.
REQ-037 300 back-to-back manual episodes -> stim_count saturates at 8'hFF without wrapping.

Source files
------------

// File: rtl/mimosa_caretaker.sv
// Care controller for the mimosa pet model: divides clk into the model heartbeat
// and applies manual or automatic stimulus episodes aligned to heartbeat falling edges.
module mimosa_caretaker #(
    parameter int unsigned TICK_DIV    = 1000,
    parameter int unsigned STIM_HOLD   = 4,
    parameter int unsigned COOLDOWN    = 8,
    parameter logic [1:0]  SLEEP_STATE = 2'b01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] status,
    input  logic       auto_en,
    input  logic       manual_valid,
    input  logic [6:0] manual_stim,
    output logic       model_clk,
    output logic [6:0] stim,
    output logic       busy,
    output logic       manual_drop,
    output logic [7:0] stim_count
);

    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);
    localparam logic [7:0]  HOLD_LIM = 8'(STIM_HOLD);
    localparam logic [7:0]  COOL_LIM = 8'(COOLDOWN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_HOLD,
        S_COOL
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] div_q;
    logic        model_clk_q;
    logic [6:0]  pend_q, pend_d;
    logic [6:0]  stim_q, stim_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  count_q, count_d;
    logic        drop_q, drop_d;

    logic        term;
    logic        rise_evt;
    logic        fall_evt;
    logic        auto_hit;
    logic [6:0]  auto_code;

    // Strobes flag the cycle whose closing edge toggles model_clk.
    assign term     = (div_q == DIV_LAST);
    assign rise_evt = term && !model_clk_q;
    assign fall_evt = term && model_clk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            model_clk_q <= 1'b0;
        end else if (term) begin
            div_q       <= '0;
            model_clk_q <= ~model_clk_q;
        end else begin
            div_q <= div_q + 16'd1;
        end
    end

    // Automatic policy: stress relief first, then hunger, then boredom.
    always_comb begin
        auto_hit  = 1'b0;
        auto_code = '0;
        if (auto_en && (status[7:6] != SLEEP_STATE)) begin
            if (status[3:2] == 2'b11) begin
                auto_hit  = 1'b1;
                auto_code = 7'b0000001;
            end else if (status[1:0] == 2'b00) begin
                auto_hit  = 1'b1;
                auto_code = 7'b0000010;
            end else if (status[5:4] == 2'b00) begin
                auto_hit  = 1'b1;
                auto_code = 7'b0000100;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            stim_q  <= '0;
            cnt_q   <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            stim_q  <= stim_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        stim_d  = stim_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        drop_d  = manual_valid && (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (manual_valid) begin
                    pend_d  = manual_stim;
                    state_d = S_ARM;
                end else if (auto_hit) begin
                    pend_d  = auto_code;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (fall_evt) begin
                    stim_d  = pend_q;
                    cnt_d   = '0;
                    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (fall_evt && (cnt_q == HOLD_LIM)) begin
                    stim_d  = '0;
                    cnt_d   = '0;
                    state_d = S_COOL;
                end else if (rise_evt) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_COOL: begin
                if (fall_evt && (cnt_q == COOL_LIM)) begin
                    state_d = S_IDLE;
                end else if (rise_evt) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign model_clk   = model_clk_q;
    assign stim        = stim_q;
    assign busy        = (state_q != S_IDLE);
    assign manual_drop = drop_q;
    assign stim_count  = count_q;

endmodule

// File: tb/tb_mimosa_caretaker.sv
// Bench for mimosa_caretaker: episode-level timing model (heartbeat edge arithmetic)
// compared every cycle against the DUT outputs.
module tb_mimosa_caretaker;

    localparam int TD = 2;
    localparam int H  = 2;
    localparam int C  = 1;
    localparam logic [1:0] SLEEP = 2'b01;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] status = '0;
    logic       auto_en = 1'b0;
    logic       manual_valid = 1'b0;
    logic [6:0] manual_stim = '0;
    logic       model_clk;
    logic [6:0] stim;
    logic       busy;
    logic       manual_drop;
    logic [7:0] stim_count;

    int tests = 0;
    int failed = 0;

    // Reference model: n = clk edges since reset release; an episode is described
    // by the edge of its first stimulus (f0) and the edge it returns to idle (m_end).
    int         n = 0;
    bit         m_busy = 0;
    int         m_f0 = 0;
    int         m_end = 0;
    logic [6:0] m_pend = '0;
    logic [7:0] m_cnt = '0;
    bit         m_drop = 0;
    int         m_eps = 0;

    mimosa_caretaker #(
        .TICK_DIV(TD),
        .STIM_HOLD(H),
        .COOLDOWN(C),
        .SLEEP_STATE(SLEEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .status(status),
        .auto_en(auto_en),
        .manual_valid(manual_valid),
        .manual_stim(manual_stim),
        .model_clk(model_clk),
        .stim(stim),
        .busy(busy),
        .manual_drop(manual_drop),
        .stim_count(stim_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit pick(input logic mv, input logic [6:0] ms, input logic ae,
                                input logic [7:0] st, output logic [6:0] code);
        code = '0;
        if (mv) begin
            code = ms;
            return 1;
        end
        if (!ae || st[7:6] == SLEEP) return 0;
        if (st[3:2] == 2'b11) begin code = 7'd1; return 1; end
        if (st[1:0] == 2'b00) begin code = 7'd2; return 1; end
        if (st[5:4] == 2'b00) begin code = 7'd4; return 1; end
        return 0;
    endfunction

    function automatic logic [6:0] exp_stim();
        if (m_busy && n >= m_f0 && n < m_f0 + 2 * TD * H) return m_pend;
        return '0;
    endfunction

    task automatic model_reset();
        n = 0; m_busy = 0; m_f0 = 0; m_end = 0;
        m_pend = '0; m_cnt = '0; m_drop = 0;
    endtask

    task automatic tick();
        logic       mv, ae;
        logic [6:0] ms, code;
        logic [7:0] st;
        mv = manual_valid; ms = manual_stim; ae = auto_en; st = status;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            n++;
            if (m_busy) begin
                m_drop = mv;
                if (n == m_f0) begin
                    m_eps++;
                    if (m_cnt != 8'hFF) m_cnt++;
                end
                if (n == m_end) m_busy = 0;
            end else begin
                m_drop = 0;
                if (pick(mv, ms, ae, st, code)) begin
                    m_busy = 1;
                    m_pend = code;
                    m_f0   = (n / (2 * TD) + 1) * 2 * TD;
                    m_end  = m_f0 + 2 * TD * (H + C);
                end
            end
        end
        #1;
        check("model_clk", {7'd0, model_clk}, {7'd0, 1'((n / TD) % 2)});
        check("stim", {1'b0, stim}, {1'b0, exp_stim()});
        check("busy", {7'd0, busy}, {7'd0, m_busy});
        check("manual_drop", {7'd0, manual_drop}, {7'd0, m_drop});
        check("stim_count", stim_count, m_cnt);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (m_busy && k < 100) begin tick(); k++; end
        tests++;
        assert (!m_busy) else begin
            failed++;
            $error("FAIL %s observed=timeout expected=idle within 100 cycles", tag);
        end
    endtask

    initial begin
        int k;
        // Reset state
        repeat (3) tick();
        check("reset_stim", {1'b0, stim}, 8'h00);
        check("reset_count", stim_count, 8'h00);
        rst = 1'b0;

        // Idle heartbeat
        repeat (100) tick();

        // Manual 0x55 episode
        manual_valid = 1'b1; manual_stim = 7'h55;
        tick();
        manual_valid = 1'b0; manual_stim = '0;
        repeat (30) tick();
        check("manual_count", stim_count, 8'h01);

        // Auto: stress beats energy
        auto_en = 1'b1; status = 8'b00_00_11_00;
        repeat (40) tick();
        auto_en = 1'b0;
        wait_idle("auto_stress_idle");

        // Sleep state suppresses auto stimuli
        auto_en = 1'b1; status = 8'b01_00_11_00;
        repeat (30) tick();
        check("sleep_busy", {7'd0, busy}, 8'h00);
        auto_en = 1'b0;

        // Manual zero pattern still runs an episode
        manual_valid = 1'b1; manual_stim = 7'h00;
        tick();
        manual_valid = 1'b0;
        repeat (4) tick();
        wait_idle("zero_stim_idle");

        // Randomized mix of manual, auto and status traffic
        for (int i = 0; i < 400; i++) begin
            manual_valid = ($urandom_range(0, 7) == 0);
            manual_stim  = 7'($urandom);
            auto_en      = 1'($urandom);
            status       = 8'($urandom);
            tick();
        end
        manual_valid = 1'b0; auto_en = 1'b0;
        wait_idle("random_idle");

        // Manual request during HOLD is dropped
        manual_valid = 1'b1; manual_stim = 7'h2A;
        tick();
        manual_valid = 1'b0;
        k = 0;
        while (exp_stim() == '0 && k < 50) begin tick(); k++; end
        tick();
        manual_valid = 1'b1; manual_stim = 7'h7F;
        tick();
        manual_valid = 1'b0;
        tick();
        wait_idle("drop_idle");

        // Reset during HOLD with feed stimulus
        auto_en = 1'b1; status = 8'b00_11_00_00;
        k = 0;
        while (exp_stim() != 7'h02 && k < 50) begin tick(); k++; end
        auto_en = 1'b0;
        tick();
        check("pre_reset_stim", {1'b0, stim}, 8'h02);
        #2 rst = 1'b1;
        #1;
        check("abort_stim", {1'b0, stim}, 8'h00);
        check("abort_model_clk", {7'd0, model_clk}, 8'h00);
        check("abort_busy", {7'd0, busy}, 8'h00);
        model_reset();
        tick();
        rst = 1'b0;
        repeat (10) tick();

        // Back-to-back manual episodes saturate the counter
        m_eps = 0;
        manual_valid = 1'b1; manual_stim = 7'h11;
        k = 0;
        while (m_eps < 300 && k < 8000) begin tick(); k++; end
        manual_valid = 1'b0;
        wait_idle("saturate_idle");
        check("saturated_count", stim_count, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
